// File: rtl/md_unit.sv
// md_unit: multiply/divide unit with architectural HI/LO registers.
// The operation is latched when start is accepted. The result is computed
// combinationally from the latched operands and written into HI/LO on the
// last busy cycle. The fixed latency models the iterative hardware that the
// pipeline's stall logic expects.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,     // asynchronous, active-low
  input  logic        start,
  input  logic [1:0]  md_op,     // 00 mult, 01 multu, 10 div, 11 divu
  input  logic [31:0] A,         // rs; also the mthi/mtlo write data
  input  logic [31:0] B,         // rt
  input  logic        hilo_we,
  input  logic        hilo_sel,  // 0 = LO, 1 = HI
  output logic        busy,
  output logic [31:0] out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     op_q, op_d;
  logic [31:0]    a_q, a_d;
  logic [31:0]    b_q, b_d;
  logic [31:0]    hi_q, hi_d;
  logic [31:0]    lo_q, lo_d;

  // Arithmetic on latched operands.
  logic        is_signed;
  logic [63:0] a_ext, b_ext, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  assign busy = (state_q == RUN);
  assign out  = hilo_sel ? hi_q : lo_q;

  // Product and quotient/remainder from the latched operands. Signed division
  // runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with remainder 0.
  always_comb begin
    is_signed = ~op_q[0];
    a_ext     = is_signed ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
    b_ext     = is_signed ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
    prod      = a_ext * b_ext;

    a_neg  = is_signed & a_q[31];
    b_neg  = is_signed & b_q[31];
    a_mag  = a_neg ? -a_q : a_q;
    b_mag  = b_neg ? -b_q : b_q;
    // A zero divisor never commits; the substitute only keeps the divider defined.
    b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quot   = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem    = a_neg ? -r_mag : r_mag;
  end

  // Next-state logic: accept start, count down, commit on the final cycle.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          // start wins over a same-cycle mthi/mtlo.
          state_d = RUN;
          op_d    = md_op;
          a_d     = A;
          b_d     = B;
          cnt_d   = md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (hilo_we) begin
          if (hilo_sel) hi_d = A;
          else          lo_d = A;
        end
      end
      RUN: begin
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          if (!op_q[1]) begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end else if (b_q != 32'd0) begin
            hi_d = rem;
            lo_d = quot;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers. Reset aborts any in-flight operation and clears HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  md_op;
  logic [31:0] A, B;
  logic        hilo_we;
  logic        hilo_sel;
  logic        busy;
  logic [31:0] out;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .A        (A),
    .B        (B),
    .hilo_we  (hilo_we),
    .hilo_sel (hilo_sel),
    .busy     (busy),
    .out      (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    md_op = op;
    A     = a;
    B     = b;
    tick();
    start = 1'b0;
  endtask

  task automatic check_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    hilo_sel = 1'b1;
    #1;
    check({tag, ".hi"}, out, exp_hi);
    hilo_sel = 1'b0;
    #1;
    check({tag, ".lo"}, out, exp_lo);
  endtask

  // Start an op and check busy stays high for exactly n cycles after the start edge.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n);
    launch(op, a, b);
    check({tag, ".busy0"}, {31'b0, busy}, 32'd1);
    for (int i = 1; i <= n; i++) begin
      tick();
      if (i == n) check({tag, ".busy_end"}, {31'b0, busy}, 32'd0);
      else if (i == n - 1) check({tag, ".busy_last"}, {31'b0, busy}, 32'd1);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; md_op = 2'b00; A = '0; B = '0;
    hilo_we = 1'b0; hilo_sel = 1'b0;
    #12;
    check("rst.busy", {31'b0, busy}, 32'd0);
    check_hilo("rst", 32'h0, 32'h0);
    reset = 1'b1;
    tick();

    // 1. multu FFFFFFFF * 2
    run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 5);
    check_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);

    // 2. mult -3 * 5
    run_op("mult", OP_MULT, 32'hFFFF_FFFD, 32'd5, 5);
    check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1);

    // 3. div -7 / 2, then divu by zero leaves HI/LO alone
    run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 10);
    check_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu0", OP_DIVU, 32'd7, 32'd0, 10);
    check_hilo("divu0", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div0", OP_DIV, 32'd9, 32'd0, 10);
    check_hilo("div0", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // Signed divide with positive dividend / negative divisor: 7 / -2 = -3 r 1
    run_op("div_pn", OP_DIV, 32'd7, 32'hFFFF_FFFE, 10);
    check_hilo("div_pn", 32'h0000_0001, 32'hFFFF_FFFD);
    // Overflow corner
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    check_hilo("div_ovf", 32'h0, 32'h8000_0000);
    // Unsigned divide, operand with top bit set: 0x80000010 / 16
    run_op("divu", OP_DIVU, 32'h8000_0010, 32'd16, 10);
    check_hilo("divu", 32'h0, 32'h0800_0001);
    run_op("divu2", OP_DIVU, 32'd100, 32'd7, 10);
    check_hilo("divu2", 32'h2, 32'hE);

    // 4. mthi idle, then mult with ignored mtlo and start during busy
    hilo_we = 1'b1; hilo_sel = 1'b1; A = 32'h1234_5678;
    tick();
    hilo_we = 1'b0;
    check("mthi", out, 32'h1234_5678);
    launch(OP_MULT, 32'd3, 32'd4);            // start edge
    tick();                                   // busy cycle 1 done
    hilo_we = 1'b1; hilo_sel = 1'b0; A = 32'h0000_AAAA;
    start = 1'b1; md_op = OP_DIVU; B = 32'd1;
    tick();                                   // edge in busy cycle 2
    hilo_we = 1'b0; start = 1'b0;
    check("busy_ign.lo_old", out, 32'hE);
    hilo_sel = 1'b1;
    #1;
    check("busy_ign.hi_old", out, 32'h1234_5678);
    tick(); tick();
    check("busy_ign.busy4", {31'b0, busy}, 32'd1);
    tick();
    check("busy_ign.no_reload", {31'b0, busy}, 32'd0);
    check_hilo("busy_ign", 32'h0, 32'h0000_000C);

    // 5. reset in cycle 3 of a div
    launch(OP_DIVU, 32'd100, 32'd7);
    tick(); tick();
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid.busy", {31'b0, busy}, 32'd0);
    check_hilo("rst_mid", 32'h0, 32'h0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check("rst_mid.busy_after", {31'b0, busy}, 32'd0);
    check_hilo("rst_mid_after", 32'h0, 32'h0);

    // 6. start and mtlo in the same idle cycle: write dropped
    hilo_we = 1'b1; hilo_sel = 1'b0;
    launch(OP_MULTU, 32'd2, 32'd3);
    hilo_we = 1'b0;
    check("same.busy", {31'b0, busy}, 32'd1);
    check("same.lo_during", out, 32'h0);
    for (int i = 0; i < 5; i++) tick();
    check("same.busy_end", {31'b0, busy}, 32'd0);
    check_hilo("same", 32'h0, 32'h0000_0006);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
